mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that responds on the core's data bus, alongside the data memory. The core writes bytes to a TX data register. The bytes are buffered in a small FIFO and serialized 8N1, LSB first, on a single output pin. The core polls a status register. Read data is zero when the block is not selected, so the SoC top ORs it with the dmem read data.

---
 rtl/mmio_uart_tx_pkg.sv | 52 +++++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/mmio_uart_tx.sv | 223 ++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared register map, status bit positions and FSM encodings for the
// memory-mapped UART transmitter. A future RX block can import the same map.
package mmio_uart_tx_pkg;

    // Default base of the 16-byte register window (only addr[31:4] is decoded)
    localparam logic [31:0] UART_BASE = 32'h1000_0000;

    // Word offsets inside the window, taken from addr[3:2]
    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_BAUD   = 2'd2;
    localparam logic [1:0] OFF_IEN    = 2'd3;

    // STATUS register bit positions
    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 8;

    // Transmit FSM state encodings
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    typedef struct packed {
        logic [3:0] count;
        logic       ovf;
        logic       empty;
        logic       full;
        logic       busy;
    } uart_status_t;

    // Places the status fields at their register bit positions; the rest read 0
    function automatic logic [31:0] pack_status(input uart_status_t s);
        logic [31:0] r;
        r = '0;
        r[ST_BUSY]                    = s.busy;
        r[ST_FULL]                    = s.full;
        r[ST_EMPTY]                   = s.empty;
        r[ST_OVF]                     = s.ovf;
        r[ST_CNT_LSB+3:ST_CNT_LSB]    = s.count;
        return r;
    endfunction

    // A divisor of 0 would stall the bit counter, so it is stored as 1
    function automatic logic [15:0] clamp_div(input logic [15:0] w);
        return (w == 16'd0) ? 16'd1 : w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop/full/empty/count. Read data is the head
// entry (first-word fall-through) so a consumer can pop and use it in the
// same cycle. A push into a full FIFO is accepted only when a pop happens
// in the same cycle. Reset is synchronous and active-low.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr_reg];

    // Storage write; contents need no reset because count guards every read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data bus.
//   0x0 TXDATA (write pushes wdata[7:0], reads 0)
//   0x4 STATUS (busy/full/empty/overflow/count; any write clears overflow)
//   0x8 BAUD   (clk cycles per bit, 0 stored as 1)
//   0xC IEN    (only when UART_TX_IRQ_EN is defined, otherwise reads 0)
// Optional feature macro: UART_TX_IRQ_EN adds the IEN register and irq port.
// rdata is zero outside the window so the SoC can OR it with dmem data.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = UART_BASE,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        tx
`ifdef UART_TX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Bus decode
    logic       sel;
    logic [1:0] off;
    logic       wr_txdata;
    logic       wr_status;
    logic       wr_baud;

    assign sel       = (addr[31:4] == BASE_ADDR[31:4]);
    assign off       = addr[3:2];
    assign wr_txdata = we & sel & (off == OFF_TXDATA);
    assign wr_status = we & sel & (off == OFF_STATUS);
    assign wr_baud   = we & sel & (off == OFF_BAUD);

    // Byte lanes and upper data bits that no register uses
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata[31:16]};

    // FIFO
    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    // Transmit state
    logic [1:0]  state_reg;
    logic [15:0] cnt_reg;
    logic [15:0] bit_div_reg;
    logic [7:0]  shift_reg;
    logic [2:0]  bit_idx_reg;
    logic        tx_reg;
    logic        busy;

    // Control registers
    logic [15:0] div_reg;
    logic        overflow_reg;

    assign busy     = (state_reg != S_IDLE);
    assign fifo_pop = ~busy & ~fifo_empty;
    assign tx       = tx_reg;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_txdata),
        .pop   (fifo_pop),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Count field is 4 bits wide: zero-extend small FIFOs bit by bit
    logic [3:0] count4;
    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
        if (gi < CW) begin : g_bit
            assign count4[gi] = fifo_count[gi];
        end else begin : g_zero
            assign count4[gi] = 1'b0;
        end
    end

    // Sticky overflow: a push into a full FIFO with no pop loses the byte
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow_reg <= 1'b0;
        end else if (wr_txdata && fifo_full && !fifo_pop) begin
            overflow_reg <= 1'b1;
        end else if (wr_status) begin
            overflow_reg <= 1'b0;
        end
    end

    // Baud divisor register; frames in flight use their own latched copy
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_reg <= DEFAULT_DIV;
        end else if (wr_baud) begin
            div_reg <= clamp_div(wdata[15:0]);
        end
    end

    // Frame serializer: start bit, 8 data bits LSB first, stop bit
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            bit_div_reg <= 16'd1;
            shift_reg   <= '0;
            bit_idx_reg <= '0;
            tx_reg      <= 1'b1;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        shift_reg   <= fifo_dout;
                        bit_div_reg <= div_reg;
                        cnt_reg     <= div_reg - 16'd1;
                        tx_reg      <= 1'b0;
                        state_reg   <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_reg == 16'd0) begin
                        tx_reg      <= shift_reg[0];
                        cnt_reg     <= bit_div_reg - 16'd1;
                        bit_idx_reg <= 3'd0;
                        state_reg   <= S_DATA;
                    end else begin
                        cnt_reg <= cnt_reg - 16'd1;
                    end
                end
                S_DATA: begin
                    if (cnt_reg == 16'd0) begin
                        cnt_reg <= bit_div_reg - 16'd1;
                        if (bit_idx_reg == 3'd7) begin
                            tx_reg    <= 1'b1;
                            state_reg <= S_STOP;
                        end else begin
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                            tx_reg      <= shift_reg[1];
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 16'd1;
                    end
                end
                S_STOP: begin
                    if (cnt_reg == 16'd0) begin
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 16'd1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    tx_reg    <= 1'b1;
                end
            endcase
        end
    end

`ifdef UART_TX_IRQ_EN
    logic [1:0] ien_reg;
    logic       irq_reg;

    assign irq = irq_reg;

    // Interrupt enable register
    always_ff @(posedge clk) begin
        if (!rst) begin
            ien_reg <= 2'b00;
        end else if (we && sel && (off == OFF_IEN)) begin
            ien_reg <= wdata[1:0];
        end
    end

    // Registered interrupt: drained-and-idle or overflow, each maskable
    always_ff @(posedge clk) begin
        if (!rst) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= (ien_reg[0] & fifo_empty & ~busy) |
                       (ien_reg[1] & overflow_reg);
        end
    end
`endif

    // Read mux, purely from address and state
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (off)
                OFF_STATUS: rdata = pack_status('{count: count4,
                                                  ovf:   overflow_reg,
                                                  empty: fifo_empty,
                                                  full:  fifo_full,
                                                  busy:  busy});
                OFF_BAUD:   rdata = {16'd0, div_reg};
`ifdef UART_TX_IRQ_EN
                OFF_IEN:    rdata = {30'd0, ien_reg};
`else
                OFF_IEN:    rdata = '0;
`endif
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a constant vector table for register access,
// hand-written frame sequences, then random bus traffic checked every cycle
// against a frame-level reference model (byte queue + elapsed-time counter).
module tb_mmio_uart_tx;

    localparam int          DEPTH  = 8;
    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] A_TX   = 32'h1000_0000;
    localparam logic [31:0] A_ST   = 32'h1000_0004;
    localparam logic [31:0] A_BAUD = 32'h1000_0008;
    localparam logic [31:0] A_IEN  = 32'h1000_000C;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        tx;
`ifdef UART_TX_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    mmio_uart_tx dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .rdata (rdata),
        .tx    (tx)
`ifdef UART_TX_IRQ_EN
        ,
        .irq   (irq)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mq[$];
    bit         m_ovf;
    int         m_div;
    bit         m_busy;
    int         m_el;
    int         m_fd;
    logic [7:0] m_byte;
    bit         m_tx;
    bit         m_valid = 1'b0;
    bit [1:0]   m_ien;
    bit         m_irq;

    function automatic bit in_win(input logic [31:0] a);
        return (a & 32'hFFFF_FFF0) == BASE;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        if (in_win(a)) begin
            case (a[3:2])
                2'd1: r = {20'd0, 4'(mq.size()), 4'd0, m_ovf, (mq.size() == 0),
                           (mq.size() == DEPTH), m_busy};
                2'd2: r = 32'(m_div);
`ifdef UART_TX_IRQ_EN
                2'd3: r = {30'd0, m_ien};
`endif
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    // One clock edge: frame timing from elapsed cycles, FIFO as a byte queue
    function automatic void m_step(input bit rn, input bit w, input logic [31:0] a, input logic [31:0] d);
        bit pop;
        bit full_pre;
        bit irq_next;
        int idx;
        if (!rn) begin
            mq.delete();
            m_ovf = 0; m_div = 868; m_busy = 0; m_el = 0; m_fd = 1;
            m_tx = 1; m_ien = 0; m_irq = 0; m_valid = 1;
            return;
        end
        irq_next = (m_ien[0] && mq.size() == 0 && !m_busy) || (m_ien[1] && m_ovf);
        full_pre = (mq.size() == DEPTH);
        pop      = !m_busy && mq.size() != 0;
        if (m_busy) begin
            m_el++;
            if (m_el == 10 * m_fd) m_busy = 0;
        end else if (pop) begin
            m_byte = mq.pop_front();
            m_busy = 1; m_el = 0; m_fd = m_div;
        end
        if (m_busy) begin
            idx  = m_el / m_fd;
            m_tx = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : m_byte[idx-1];
        end else begin
            m_tx = 1'b1;
        end
        if (w && in_win(a)) begin
            case (a[3:2])
                2'd0: if (full_pre && !pop) m_ovf = 1; else mq.push_back(d[7:0]);
                2'd1: m_ovf = 0;
                2'd2: m_div = (d[15:0] == 16'd0) ? 1 : int'(d[15:0]);
                default: m_ien = d[1:0];
            endcase
        end
        m_irq = irq_next;
    endfunction

    // One bus cycle: drive, compare rdata pre-edge, clock, compare outputs
    task automatic cyc(input bit rn, input bit w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd);
        rst = rn; we = w; addr = a; wdata = d;
        #1;
        rd = rdata;
        if (m_valid) check($sformatf("rdata@%08h", a), rdata, m_read(a));
        @(posedge clk);
        m_step(rn, w, a, d);
        #1;
        if (m_valid) check("tx", {31'd0, tx}, {31'd0, m_tx});
`ifdef UART_TX_IRQ_EN
        if (m_valid) check("irq", {31'd0, irq}, {31'd0, m_irq});
`endif
    endtask

    logic [31:0] rd_x;

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, A_ST, 32'd0, rd_x);
    endtask

    typedef struct {
        bit          rn;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        bit          exp_tx;
    } vec_t;

    vec_t tbl[16];

    initial begin
        logic [31:0] rd;
        logic [9:0]  frame;
        int          n_low;
        int          n_busy;

        tbl[0]  = '{1, 0, A_ST,          32'd0,          32'h0000_0004, 1};
        tbl[1]  = '{1, 0, A_BAUD,        32'd0,          32'd868,       1};
        tbl[2]  = '{1, 0, A_TX,          32'd0,          32'd0,         1};
        tbl[3]  = '{1, 0, A_IEN,         32'd0,          32'd0,         1};
        tbl[4]  = '{1, 1, 32'h2000_0000, 32'h55,         32'd0,         1};
        tbl[5]  = '{1, 1, 32'h2000_0008, 32'd3,          32'd0,         1};
        tbl[6]  = '{1, 0, A_ST,          32'd0,          32'h0000_0004, 1};
        tbl[7]  = '{1, 0, A_BAUD,        32'd0,          32'd868,       1};
        tbl[8]  = '{1, 1, A_BAUD,        32'd0,          32'd868,       1};
        tbl[9]  = '{1, 0, A_BAUD,        32'd0,          32'd1,         1};
        tbl[10] = '{1, 1, A_BAUD,        32'h1234_0004,  32'd1,         1};
        tbl[11] = '{1, 0, A_BAUD,        32'd0,          32'd4,         1};
        tbl[12] = '{1, 1, A_ST,          32'hFFFF_FFFF,  32'h0000_0004, 1};
        tbl[13] = '{1, 0, A_ST,          32'd0,          32'h0000_0004, 1};
        tbl[14] = '{1, 1, A_BAUD + 1,    32'd4,          32'd4,         1};
        tbl[15] = '{1, 0, A_BAUD + 2,    32'd0,          32'd4,         1};

        rst = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, A_ST, 32'd0, rd);
        check("reset_tx", {31'd0, tx}, 32'd1);

        // Register access table
        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].rn, tbl[i].w, tbl[i].a, tbl[i].d, rd);
            check($sformatf("vec%0d_rd", i), rd, tbl[i].exp_rd);
            check($sformatf("vec%0d_tx", i), {31'd0, tx}, {31'd0, tbl[i].exp_tx});
            $display("vec %0d addr=%08h we=%0d wdata=%08h rdata=%08h tx=%0b",
                     i, tbl[i].a, tbl[i].w, tbl[i].d, rd, tx);
        end

        // 0x55 at 4 cycles per bit
        cyc(1'b1, 1'b1, A_TX, 32'h55, rd);
        check("pre_start_tx", {31'd0, tx}, 32'd1);
        frame = {1'b1, 8'h55, 1'b0};
        for (int k = 0; k < 40; k++) begin
            cyc(1'b1, 1'b0, A_ST, 32'd0, rd);
            if (k % 4 == 0) check($sformatf("f55_bit%0d", k / 4), {31'd0, tx}, {31'd0, frame[k/4]});
        end
        cyc(1'b1, 1'b0, A_ST, 32'd0, rd);
        check("f55_busy_last", rd, 32'h0000_0005);
        cyc(1'b1, 1'b0, A_ST, 32'd0, rd);
        check("f55_busy_clear", rd, 32'h0000_0004);
        $display("seq frame55 done tx=%0b", tx);

        // FIFO fill and overflow at 2 cycles per bit
        cyc(1'b1, 1'b1, A_BAUD, 32'd2, rd);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, A_TX, 32'hA0 + 32'(i), rd);
        cyc(1'b1, 1'b1, A_ST, 32'd0, rd);
        check("ovf_set", rd, 32'h0000_080B);
        cyc(1'b1, 1'b0, A_ST, 32'd0, rd);
        check("ovf_clear", rd, 32'h0000_0803);
        idle(200);
        cyc(1'b1, 1'b0, A_ST, 32'd0, rd);
        check("drained", rd, 32'h0000_0004);
        $display("seq overflow done status=%08h", rd);

        // Divisor 0 -> 1: 0xFF frame is 10 cycles with a single low cycle
        cyc(1'b1, 1'b1, A_BAUD, 32'd0, rd);
        cyc(1'b1, 1'b1, A_TX, 32'hFF, rd);
        n_low = 0; n_busy = 0;
        for (int k = 0; k < 14; k++) begin
            cyc(1'b1, 1'b0, A_ST, 32'd0, rd);
            if (rd[0]) n_busy++;
            if (!tx) n_low++;
        end
        check("ff_busy_cycles", 32'(n_busy), 32'd10);
        check("ff_low_cycles", 32'(n_low), 32'd1);
        $display("seq div1 done busy=%0d low=%0d", n_busy, n_low);

        // Reset in the middle of the data bits
        cyc(1'b1, 1'b1, A_BAUD, 32'd4, rd);
        cyc(1'b1, 1'b1, A_TX, 32'hA5, rd);
        cyc(1'b1, 1'b1, A_TX, 32'h3C, rd);
        idle(12);
        cyc(1'b0, 1'b0, A_ST, 32'd0, rd);
        check("rst_tx", {31'd0, tx}, 32'd1);
        cyc(1'b1, 1'b0, A_ST, 32'd0, rd);
        check("rst_status", rd, 32'h0000_0004);
        cyc(1'b1, 1'b0, A_BAUD, 32'd0, rd);
        check("rst_baud", rd, 32'd868);
        n_low = 0;
        for (int k = 0; k < 30; k++) begin
            cyc(1'b1, 1'b0, A_ST, 32'd0, rd);
            if (!tx) n_low++;
        end
        check("rst_no_residual", 32'(n_low), 32'd0);
        $display("seq midframe reset done");

        // Random traffic against the model
        cyc(1'b1, 1'b1, A_BAUD, 32'($urandom_range(1, 4)), rd);
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 25)      cyc(1'b1, 1'b1, A_TX, $urandom, rd);
            else if (r < 28) cyc(1'b1, 1'b1, A_BAUD, 32'($urandom_range(0, 4)), rd);
            else if (r < 31) cyc(1'b1, 1'b1, A_ST, $urandom, rd);
            else if (r < 33) cyc(1'b1, 1'b1, {4'h2, 28'($urandom)}, $urandom, rd);
            else if (r < 35) cyc(1'b1, 1'b1, A_IEN, $urandom, rd);
            else if (r < 36) begin
                cyc(1'b0, 1'b0, A_ST, 32'd0, rd);
                cyc(1'b1, 1'b1, A_BAUD, 32'($urandom_range(1, 4)), rd);
            end
            else             cyc(1'b1, 1'b0, BASE + 32'($urandom_range(0, 15)), $urandom, rd);
        end
        idle(400);
        $display("seq random done queued=%0d", mq.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
